// File: rtl/tic_tac_toe_pkg.sv
// Shared encodings for the tic-tac-toe design: cell codes, direction and
// winner codes, and the board controller FSM state type.
package tic_tac_toe_pkg;

  localparam logic [1:0] CELL_O     = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_EMPTY = 2'b10;

  localparam logic [17:0] BOARD_EMPTY = 18'h2AAAA;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [1:0] {
    StPlay  = 2'b00,
    StCheck = 2'b01,
    StOver  = 2'b10
  } state_e;

endpackage

// File: rtl/cursor_mover.sv
// Combinational cursor step on the 3x3 grid; moves wrap within the row or
// column. An out-of-range cursor is pulled back to the start cell.
module cursor_mover
  import tic_tac_toe_pkg::*;
#(
  parameter int unsigned START_CURSOR = 4
) (
  input  logic [3:0] cursor,
  input  logic [1:0] dir,
  output logic [3:0] next_cursor
);

  logic       valid;
  logic [1:0] row, col, nrow, ncol;

  always_comb begin
    valid = (cursor <= 4'd8);
    row   = 2'(cursor / 4'd3);
    col   = 2'(cursor % 4'd3);
    nrow  = row;
    ncol  = col;
    case (dir)
      DIR_UP:    nrow = (row == 2'd0) ? 2'd2 : row - 2'd1;
      DIR_DOWN:  nrow = (row == 2'd2) ? 2'd0 : row + 2'd1;
      DIR_LEFT:  ncol = (col == 2'd0) ? 2'd2 : col - 2'd1;
      DIR_RIGHT: ncol = (col == 2'd2) ? 2'd0 : col + 2'd1;
      default: ;
    endcase
    if (valid) begin
      next_cursor = {2'b00, nrow} * 4'd3 + {2'b00, ncol};
    end else begin
      next_cursor = 4'(START_CURSOR);
    end
  end

endmodule

// File: rtl/board_controller.sv
// Game-state owner: board, cursor and current player, with a one-cycle CHECK
// state so the external win checker sees the freshly placed piece.
module board_controller
  import tic_tac_toe_pkg::*;
#(
  parameter int unsigned START_CURSOR = 4,
  parameter logic        START_PLAYER = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  dir,
  input  logic        move_valid,
  input  logic        place,
  input  logic        new_game,
  input  logic [1:0]  winner,
  output logic [17:0] board,
  output logic [3:0]  cursor,
  output logic        player,
  output logic        place_reject,
  output logic        game_over,
  output logic [1:0]  result
);

  state_e      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [3:0]  cursor_q, cursor_d;
  logic        player_q, player_d;
  logic        reject_q, reject_d;
  logic        over_q, over_d;
  logic [1:0]  result_q, result_d;

  logic [3:0]  moved_cursor;
  logic [1:0]  cur_cell;
  logic        cur_empty;

  cursor_mover #(
    .START_CURSOR(START_CURSOR)
  ) u_cursor_mover (
    .cursor     (cursor_q),
    .dir        (dir),
    .next_cursor(moved_cursor)
  );

  // Out-of-range cursor reads as occupied, so it can never write the board.
  always_comb begin
    cur_cell = CELL_O;
    for (int i = 0; i < 9; i++) begin
      if (cursor_q == 4'(i)) cur_cell = board_q[2*i +: 2];
    end
    cur_empty = (cur_cell == CELL_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StPlay;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = StPlay;
    end else begin
      unique case (state_q)
        StPlay:  if (place && cur_empty) state_d = StCheck;
        StCheck: state_d = (winner != WIN_NONE) ? StOver : StPlay;
        StOver:  state_d = StOver;
        default: state_d = StPlay;
      endcase
    end
  end

  always_comb begin
    board_d  = board_q;
    cursor_d = cursor_q;
    player_d = player_q;
    result_d = result_q;
    reject_d = 1'b0;
    over_d   = (state_d == StOver);
    if (new_game) begin
      board_d  = BOARD_EMPTY;
      cursor_d = 4'(START_CURSOR);
      player_d = START_PLAYER;
      result_d = WIN_NONE;
    end else begin
      unique case (state_q)
        StPlay: begin
          // place wins over move_valid, even when the place is rejected
          if (place) begin
            if (cur_empty) begin
              for (int i = 0; i < 9; i++) begin
                if (cursor_q == 4'(i)) board_d[2*i +: 2] = player_q ? CELL_X : CELL_O;
              end
            end else begin
              reject_d = 1'b1;
            end
          end else if (move_valid) begin
            cursor_d = moved_cursor;
          end
        end
        StCheck: begin
          if (winner != WIN_NONE) begin
            result_d = winner;
          end else begin
            player_d = ~player_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      board_q  <= BOARD_EMPTY;
      cursor_q <= 4'(START_CURSOR);
      player_q <= START_PLAYER;
      reject_q <= 1'b0;
      over_q   <= 1'b0;
      result_q <= WIN_NONE;
    end else begin
      board_q  <= board_d;
      cursor_q <= cursor_d;
      player_q <= player_d;
      reject_q <= reject_d;
      over_q   <= over_d;
      result_q <= result_d;
    end
  end

  assign board        = board_q;
  assign cursor       = cursor_q;
  assign player       = player_q;
  assign place_reject = reject_q;
  assign game_over    = over_q;
  assign result       = result_q;

endmodule

// File: tb/tb_board_controller.sv
// Scoreboard bench for board_controller: stimulus queues expected state per
// cycle, a negedge monitor pops and compares against the DUT outputs.
module tb_board_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  dir;
  logic        move_valid;
  logic        place;
  logic        new_game;
  logic [1:0]  winner;
  logic [17:0] board;
  logic [3:0]  cursor;
  logic        player;
  logic        place_reject;
  logic        game_over;
  logic [1:0]  result;

  board_controller #(
    .START_CURSOR(4),
    .START_PLAYER(1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dir         (dir),
    .move_valid  (move_valid),
    .place       (place),
    .new_game    (new_game),
    .winner      (winner),
    .board       (board),
    .cursor      (cursor),
    .player      (player),
    .place_reject(place_reject),
    .game_over   (game_over),
    .result      (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [17:0] board;
    logic [3:0]  cursor;
    logic        player;
    logic        reject;
    logic        over;
    logic [1:0]  result;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [17:0] e_board;
  logic [3:0]  e_cursor;
  logic        e_player;
  logic        e_reject;
  logic        e_over;
  logic [1:0]  e_result;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      got = sb.pop_front();
      checks++;
      if (got.cyc != cyc) begin
        errors++;
        $display("FAIL %s: stale entry for cycle %0d at cycle %0d", got.name, got.cyc, cyc);
      end else if (board !== got.board || cursor !== got.cursor || player !== got.player ||
                   place_reject !== got.reject || game_over !== got.over ||
                   result !== got.result) begin
        errors++;
        $display("FAIL %s: got board=%h cur=%0d ply=%b rej=%b over=%b res=%b, want board=%h cur=%0d ply=%b rej=%b over=%b res=%b",
                 got.name, board, cursor, player, place_reject, game_over, result,
                 got.board, got.cursor, got.player, got.reject, got.over, got.result);
      end
    end
  end

  // Queue the expected post-edge state, clock once, then drop the pulses.
  task automatic tick(input string nm);
    exp_t e;
    e.cyc    = cyc + 1;
    e.name   = nm;
    e.board  = e_board;
    e.cursor = e_cursor;
    e.player = e_player;
    e.reject = e_reject;
    e.over   = e_over;
    e.result = e_result;
    sb.push_back(e);
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    place      = 1'b0;
    new_game   = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic mv(input logic [1:0] d, input logic [3:0] exp_cur, input string nm);
    dir        = d;
    move_valid = 1'b1;
    e_cursor   = exp_cur;
    tick(nm);
  endtask

  task automatic exp_reset_state();
    e_board  = 18'h2AAAA;
    e_cursor = 4'd4;
    e_player = 1'b0;
    e_reject = 1'b0;
    e_over   = 1'b0;
    e_result = 2'b00;
  endtask

  initial begin
    reset = 1'b1; dir = 2'b00; move_valid = 1'b0; place = 1'b0;
    new_game = 1'b0; winner = 2'b00;
    repeat (2) @(posedge clk);
    #1;

    reset = 1'b1;
    exp_reset_state();
    tick("reset");

    mv(2'b00, 4'd1, "up_4_1");
    mv(2'b00, 4'd7, "up_1_7");
    mv(2'b00, 4'd4, "up_7_4");
    mv(2'b11, 4'd5, "right_4_5");
    mv(2'b11, 4'd3, "right_5_3");
    mv(2'b10, 4'd5, "left_3_5");
    mv(2'b10, 4'd4, "left_5_4");

    place = 1'b1; e_board = 18'h2A8AA;
    tick("place4_board");
    e_player = 1'b1;
    tick("place4_toggle");

    place = 1'b1; e_reject = 1'b1;
    tick("reject_pulse");
    e_reject = 1'b0;
    tick("reject_clear");

    mv(2'b00, 4'd1, "up_4_1b");
    mv(2'b10, 4'd0, "left_1_0");

    place = 1'b1; move_valid = 1'b1; dir = 2'b01; e_board = 18'h2A8A9;
    tick("place_move_prio");
    e_player = 1'b0;
    tick("place0_toggle");

    place = 1'b1; move_valid = 1'b1; dir = 2'b01; e_reject = 1'b1;
    tick("reject_move_drop");
    e_reject = 1'b0;
    tick("reject_move_clear");

    mv(2'b11, 4'd1, "right_0_1");
    place = 1'b1; e_board = 18'h2A8A1;
    tick("place1_board");
    winner = 2'b01; e_over = 1'b1; e_result = 2'b01;
    tick("win_over");
    winner = 2'b00;
    place = 1'b1; move_valid = 1'b1; dir = 2'b01;
    tick("over_ignore");
    tick("over_hold");

    new_game = 1'b1;
    exp_reset_state();
    tick("new_game");

    place = 1'b1; e_board = 18'h2A8AA;
    tick("place4_again");
    reset = 1'b1; winner = 2'b01;
    exp_reset_state();
    tick("reset_in_check");
    winner = 2'b00;
    tick("after_reset_idle");
    mv(2'b01, 4'd7, "down_4_7");
    mv(2'b01, 4'd1, "down_7_1");

    repeat (2) @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
